// File: rtl/game_clock_timer.sv
// Scoreboard game clock: counts a period down from PERIOD_MIN:00 to 00:00 in BCD,
// driven by the divider's 1 s tap, with run/pause, period advance, buzzer and game-over.
module game_clock_timer #(
    parameter int PERIOD_MIN   = 10,
    parameter int NUM_PERIODS  = 4,
    parameter int BUZZ_SECONDS = 2
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       start_pause,
    input  logic       next_period,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic [2:0] period,
    output logic       running,
    output logic       expired,
    output logic       buzzer,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED,
        S_GAME_OVER
    } state_t;

    localparam logic [3:0] LOAD_TENS   = 4'(PERIOD_MIN / 10);
    localparam logic [3:0] LOAD_UNITS  = 4'(PERIOD_MIN % 10);
    localparam logic [3:0] BUZZ_LOAD   = 4'(BUZZ_SECONDS);
    localparam logic [2:0] LAST_PERIOD = 3'(NUM_PERIODS);

    state_t     state_reg, state_next;
    logic [3:0] mt_reg, mu_reg, st_reg, su_reg;
    logic [3:0] mt_next, mu_next, st_next, su_next;
    logic [3:0] mt_dec, mu_dec, st_dec, su_dec;
    logic [2:0] period_reg, period_next;
    logic       buzz_reg, buzz_next;
    logic [3:0] buzz_cnt_reg, buzz_cnt_next;
    logic [2:0] btn_in, btn_rise;
    logic       tick_rise, sp_rise, np_rise;
    logic       time_zero, time_one;

    // Edge registers reset high so an input already high at release is not an edge.
    assign btn_in = {next_period, start_pause, tick_in};
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_edge
            logic d_reg;
            always_ff @(posedge clock_in) begin
                if (reset) d_reg <= 1'b1;
                else       d_reg <= btn_in[gi];
            end
            assign btn_rise[gi] = btn_in[gi] & ~d_reg;
        end
    endgenerate
    assign tick_rise = btn_rise[0];
    assign sp_rise   = btn_rise[1];
    assign np_rise   = btn_rise[2];

    assign time_zero = (mt_reg == 4'd0) && (mu_reg == 4'd0) && (st_reg == 4'd0) && (su_reg == 4'd0);
    assign time_one  = (mt_reg == 4'd0) && (mu_reg == 4'd0) && (st_reg == 4'd0) && (su_reg == 4'd1);

    // BCD borrow chain; only applied when the time is non-zero.
    always_comb begin
        mt_dec = mt_reg;
        mu_dec = mu_reg;
        st_dec = st_reg;
        su_dec = su_reg - 4'd1;
        if (su_reg == 4'd0) begin
            su_dec = 4'd9;
            st_dec = st_reg - 4'd1;
            if (st_reg == 4'd0) begin
                st_dec = 4'd5;
                mu_dec = mu_reg - 4'd1;
                if (mu_reg == 4'd0) begin
                    mu_dec = 4'd9;
                    mt_dec = mt_reg - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        mt_next       = mt_reg;
        mu_next       = mu_reg;
        st_next       = st_reg;
        su_next       = su_reg;
        period_next   = period_reg;
        buzz_next     = buzz_reg;
        buzz_cnt_next = buzz_cnt_reg;

        if (buzz_reg && tick_rise) begin
            buzz_cnt_next = buzz_cnt_reg - 4'd1;
            if (buzz_cnt_reg <= 4'd1) buzz_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                if (sp_rise) state_next = S_RUN;
            end
            S_RUN: begin
                if (tick_rise && !time_zero) begin
                    mt_next = mt_dec;
                    mu_next = mu_dec;
                    st_next = st_dec;
                    su_next = su_dec;
                    // Expiry takes priority over a same-cycle pause press.
                    if (time_one) begin
                        state_next    = (period_reg < LAST_PERIOD) ? S_EXPIRED : S_GAME_OVER;
                        buzz_next     = 1'b1;
                        buzz_cnt_next = BUZZ_LOAD;
                    end else if (sp_rise) begin
                        state_next = S_PAUSE;
                    end
                end else if (sp_rise) begin
                    state_next = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (sp_rise) state_next = S_RUN;
            end
            S_EXPIRED: begin
                if (np_rise) begin
                    period_next = period_reg + 3'd1;
                    mt_next     = LOAD_TENS;
                    mu_next     = LOAD_UNITS;
                    st_next     = 4'd0;
                    su_next     = 4'd0;
                    buzz_next   = 1'b0;
                    state_next  = S_IDLE;
                end
            end
            S_GAME_OVER: begin
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            mt_reg       <= LOAD_TENS;
            mu_reg       <= LOAD_UNITS;
            st_reg       <= 4'd0;
            su_reg       <= 4'd0;
            period_reg   <= 3'd1;
            buzz_reg     <= 1'b0;
            buzz_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            mt_reg       <= mt_next;
            mu_reg       <= mu_next;
            st_reg       <= st_next;
            su_reg       <= su_next;
            period_reg   <= period_next;
            buzz_reg     <= buzz_next;
            buzz_cnt_reg <= buzz_cnt_next;
        end
    end

    assign min_tens  = mt_reg;
    assign min_units = mu_reg;
    assign sec_tens  = st_reg;
    assign sec_units = su_reg;
    assign period    = period_reg;
    assign running   = (state_reg == S_RUN);
    assign expired   = (state_reg == S_EXPIRED) || (state_reg == S_GAME_OVER);
    assign game_over = (state_reg == S_GAME_OVER);
    assign buzzer    = buzz_reg;

endmodule

// File: tb/tb_game_clock_timer.sv
// Bench for game_clock_timer: two instances (10 min x 4 periods, 1 min x 2 periods)
// checked every cycle against a seconds-based model through an expected-value queue.
module tb_game_clock_timer;

    logic       clk = 1'b0;
    logic       rst_s [2];
    logic       tk_s  [2];
    logic       sp_s  [2];
    logic       np_s  [2];
    logic [3:0] mt [2];
    logic [3:0] mu [2];
    logic [3:0] st [2];
    logic [3:0] su [2];
    logic [2:0] per [2];
    logic       run_o [2];
    logic       exp_o [2];
    logic       buzz_o [2];
    logic       go_o [2];

    always #5 clk = ~clk;

    game_clock_timer #(.PERIOD_MIN(10), .NUM_PERIODS(4), .BUZZ_SECONDS(2)) dut_a (
        .clock_in(clk), .reset(rst_s[0]), .tick_in(tk_s[0]), .start_pause(sp_s[0]),
        .next_period(np_s[0]), .min_tens(mt[0]), .min_units(mu[0]), .sec_tens(st[0]),
        .sec_units(su[0]), .period(per[0]), .running(run_o[0]), .expired(exp_o[0]),
        .buzzer(buzz_o[0]), .game_over(go_o[0])
    );

    game_clock_timer #(.PERIOD_MIN(1), .NUM_PERIODS(2), .BUZZ_SECONDS(2)) dut_b (
        .clock_in(clk), .reset(rst_s[1]), .tick_in(tk_s[1]), .start_pause(sp_s[1]),
        .next_period(np_s[1]), .min_tens(mt[1]), .min_units(mu[1]), .sec_tens(st[1]),
        .sec_units(su[1]), .period(per[1]), .running(run_o[1]), .expired(exp_o[1]),
        .buzzer(buzz_o[1]), .game_over(go_o[1])
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [22:0] exp_q [$];

    // Model: state 0 idle, 1 run, 2 pause, 3 expired, 4 game over; time in whole seconds.
    int m_st [2];
    int m_secs [2];
    int m_per [2];
    int m_bcnt [2];
    bit m_buzz [2];
    bit pt [2];
    bit ps [2];
    bit pn [2];

    function automatic int pm_of(int k);
        return (k == 0) ? 10 : 1;
    endfunction

    function automatic int np_of(int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic logic [22:0] model_vec(int k);
        int mins = m_secs[k] / 60;
        int secs = m_secs[k] % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), 3'(m_per[k]),
                m_st[k] == 1, m_st[k] >= 3, m_buzz[k], m_st[k] == 4};
    endfunction

    function automatic logic [22:0] act_vec(int k);
        return {mt[k], mu[k], st[k], su[k], per[k], run_o[k], exp_o[k], buzz_o[k], go_o[k]};
    endfunction

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] expv, bit verbose);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, got, expv);
        end else if (verbose) begin
            $display("[%0t] %s: observed %h expected %h ok", $time, tag, got, expv);
        end
    endtask

    task automatic model_step(int k);
        bit te, se, ne;
        if (rst_s[k]) begin
            m_st[k] = 0; m_secs[k] = pm_of(k) * 60; m_per[k] = 1;
            m_buzz[k] = 0; m_bcnt[k] = 0;
            pt[k] = 1; ps[k] = 1; pn[k] = 1;
        end else begin
            te = tk_s[k] && !pt[k];
            se = sp_s[k] && !ps[k];
            ne = np_s[k] && !pn[k];
            pt[k] = tk_s[k]; ps[k] = sp_s[k]; pn[k] = np_s[k];
            if (m_buzz[k] && te) begin
                m_bcnt[k]--;
                if (m_bcnt[k] <= 0) m_buzz[k] = 0;
            end
            case (m_st[k])
                0: if (se) m_st[k] = 1;
                1: begin
                    if (te && m_secs[k] > 0) begin
                        m_secs[k]--;
                        if (m_secs[k] == 0) begin
                            m_st[k] = (m_per[k] < np_of(k)) ? 3 : 4;
                            m_buzz[k] = 1;
                            m_bcnt[k] = 2;
                        end else if (se) m_st[k] = 2;
                    end else if (se) m_st[k] = 2;
                end
                2: if (se) m_st[k] = 1;
                3: if (ne) begin
                    m_per[k]++; m_secs[k] = pm_of(k) * 60; m_st[k] = 0; m_buzz[k] = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(int u, bit r, bit t, bit s, bit n, string tag);
        logic [22:0] e;
        rst_s[u] = r; tk_s[u] = t; sp_s[u] = s; np_s[u] = n;
        for (int k = 0; k < 2; k++) model_step(k);
        exp_q.push_back(model_vec(u));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val((tag == "") ? "cycle" : tag, 32'(act_vec(u)), 32'(e), tag != "");
    endtask

    task automatic pulse(int u, bit t, bit s, bit n, string tag);
        step(u, 1'b0, t, s, n, tag);
        step(u, 1'b0, 1'b0, 1'b0, 1'b0, "");
    endtask

    task automatic tick_n(int u, int cnt);
        for (int i = 0; i < cnt; i++) pulse(u, 1'b1, 1'b0, 1'b0, "");
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_s[k] = 1'b1; tk_s[k] = 1'b0; sp_s[k] = 1'b0; np_s[k] = 1'b0;
        end
        tk_s[0] = 1'b1;

        step(0, 1'b1, 1'b1, 1'b0, 1'b0, "");
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, "reset_state");
        rst_s[1] = 1'b0;
        step(0, 1'b0, 1'b1, 1'b0, 1'b0, "release_tick_high");
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, "");

        pulse(0, 1'b0, 1'b1, 1'b0, "start");
        pulse(0, 1'b1, 1'b0, 1'b0, "borrow_10_00");
        pulse(0, 1'b1, 1'b0, 1'b0, "");
        pulse(0, 1'b1, 1'b0, 1'b0, "run_3_ticks");
        pulse(0, 1'b0, 1'b0, 1'b1, "np_ignored_run");
        pulse(0, 1'b0, 1'b1, 1'b0, "pause");
        tick_n(0, 4);
        pulse(0, 1'b1, 1'b0, 1'b0, "paused_5_ticks");
        pulse(0, 1'b0, 1'b1, 1'b0, "resume");
        tick_n(0, 296);
        pulse(0, 1'b1, 1'b0, 1'b0, "at_05_00");
        pulse(0, 1'b1, 1'b1, 1'b0, "tick_press_in_run");
        pulse(0, 1'b1, 1'b1, 1'b0, "tick_press_in_pause");
        tick_n(0, 239);
        pulse(0, 1'b1, 1'b0, 1'b0, "borrow_01_00");
        tick_n(0, 58);
        pulse(0, 1'b1, 1'b1, 1'b0, "final_tick_with_press");
        pulse(0, 1'b0, 1'b1, 1'b0, "press_ignored_expired");
        pulse(0, 1'b0, 1'b0, 1'b1, "next_period_clears_buzz");
        pulse(0, 1'b0, 1'b1, 1'b0, "restart_p2");
        pulse(0, 1'b1, 1'b0, 1'b0, "tick_p2");
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, "reset_mid_run");
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, "");

        pulse(1, 1'b0, 1'b1, 1'b0, "u1_start");
        tick_n(1, 59);
        pulse(1, 1'b1, 1'b0, 1'b0, "u1_expire");
        pulse(1, 1'b1, 1'b0, 1'b0, "u1_buzz_1tick");
        pulse(1, 1'b1, 1'b0, 1'b0, "u1_buzz_2ticks");
        pulse(1, 1'b0, 1'b0, 1'b1, "u1_next_period");
        pulse(1, 1'b0, 1'b1, 1'b0, "u1_start_p2");
        tick_n(1, 59);
        pulse(1, 1'b1, 1'b0, 1'b0, "u1_game_over");
        tick_n(1, 2);
        pulse(1, 1'b0, 1'b0, 1'b1, "u1_np_ignored_go");
        pulse(1, 1'b0, 1'b1, 1'b0, "u1_sp_ignored_go");
        step(1, 1'b1, 1'b0, 1'b0, 1'b0, "u1_reset_go");
        step(1, 1'b0, 1'b0, 1'b0, 1'b0, "u1_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
